// File: rtl/packet_pkg.sv
// Shared packet-field widths and arbiter state encoding for the 4-port switch.
package packet_pkg;
    localparam int ADDR_WIDTH     = 4;
    localparam int PKT_DATA_WIDTH = 8;
    localparam int PKT_NUM_PORTS  = 4;
    localparam int PKT_WAIT_LIMIT = 15;
    localparam int WAIT_W         = $clog2(PKT_WAIT_LIMIT + 1);

    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

    function automatic int wait_width(input int limit);
        return $clog2(limit + 1);
    endfunction
endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: the first set request after ptr_i (wrapping) wins.
module rr_picker #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic                 any_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic [NUM_PORTS-1:0] onehot_o
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        any_o    = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_PORTS);
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/output_port_arbiter.sv
// Per-output round-robin scheduler: picks one head-of-FIFO packet targeting this
// output, holds it under valid/ready, strobes served[] and flags starved requesters.
module output_port_arbiter
    import packet_pkg::*;
#(
    parameter int NUM_PORTS  = PKT_NUM_PORTS,
    parameter int DATA_WIDTH = PKT_DATA_WIDTH,
    parameter int PORT_ID    = 0,
    parameter int WAIT_LIMIT = PKT_WAIT_LIMIT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_source,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_target,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_PORTS-1:0]             served,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ADDR_WIDTH-1:0]            out_source,
    output logic [ADDR_WIDTH-1:0]            out_target,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [$clog2(NUM_PORTS)-1:0]     grant_idx,
    output logic                             starve_alert
);
    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = wait_width(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, tgt_q, tgt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]      grant_q, grant_d, ptr_q, ptr_d;
    logic [CNT_W-1:0]      wcnt_q [NUM_PORTS];
    logic [CNT_W-1:0]      wcnt_d [NUM_PORTS];

    logic [NUM_PORTS-1:0]  req, pick_onehot, take;
    logic                  pick_any, load;
    logic [IDX_W-1:0]      pick_idx;
    logic [ADDR_WIDTH-1:0] src_arr [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] tgt_arr [NUM_PORTS];
    logic [DATA_WIDTH-1:0] data_arr [NUM_PORTS];
    logic                  unused_target;

    // Only this output's bit of the target mask makes a port eligible here.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign req[g]      = req_valid[g] & req_target[g*ADDR_WIDTH + PORT_ID];
        assign src_arr[g]  = req_source[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign tgt_arr[g]  = req_target[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end
    assign unused_target = ^req_target;

    rr_picker #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_picker (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        tgt_d   = tgt_q;
        data_d  = data_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        load    = 1'b0;
        case (state_q)
            ARB_IDLE: load = pick_any;
            ARB_HOLD: begin
                if (out_ready) begin
                    load = pick_any;
                    if (!pick_any) state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (load) begin
            state_d = ARB_HOLD;
            src_d   = src_arr[pick_idx];
            tgt_d   = tgt_arr[pick_idx];
            data_d  = data_arr[pick_idx];
            grant_d = pick_idx;
            ptr_d   = pick_idx;
        end
        take = load ? pick_onehot : '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (take[i] || !req[i])    wcnt_d[i] = '0;
            else if (wcnt_q[i] != LIMIT) wcnt_d[i] = wcnt_q[i] + 1'b1;
            else                       wcnt_d[i] = wcnt_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            src_q   <= '0;
            tgt_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
            ptr_q   <= IDX_W'(NUM_PORTS - 1);
            for (int i = 0; i < NUM_PORTS; i++) wcnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            tgt_q   <= tgt_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            for (int i = 0; i < NUM_PORTS; i++) wcnt_q[i] <= wcnt_d[i];
        end
    end

    always_comb begin
        starve_alert = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (wcnt_q[i] == LIMIT) starve_alert = 1'b1;
    end

    // served is combinational, so it must be gated while reset is held.
    assign served     = rst ? '0 : take;
    assign out_valid  = (state_q == ARB_HOLD);
    assign out_source = src_q;
    assign out_target = tgt_q;
    assign out_data   = data_q;
    assign grant_idx  = grant_q;
endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter (PORT_ID=1): a FIFO model feeds the
// request heads, expected packets are queued at stimulus time and a monitor checks them.
module tb_output_port_arbiter;
    localparam int NP  = 4;
    localparam int DW  = 8;
    localparam int PID = 1;
    localparam int WL  = 15;

    logic          clk, rst;
    logic [NP-1:0] req_valid;
    logic [NP*4-1:0] req_source, req_target;
    logic [NP*DW-1:0] req_data;
    logic [NP-1:0] served;
    logic          out_valid, out_ready;
    logic [3:0]    out_source, out_target;
    logic [DW-1:0] out_data;
    logic [1:0]    grant_idx;
    logic          starve_alert;

    logic [15:0] fifo [NP][$];
    logic [17:0] exp_q [$];
    int vectors    = 0;
    int miscompares = 0;

    output_port_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PORT_ID(PID), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_source(req_source),
        .req_target(req_target), .req_data(req_data), .served(served),
        .out_valid(out_valid), .out_ready(out_ready), .out_source(out_source),
        .out_target(out_target), .out_data(out_data), .grant_idx(grant_idx),
        .starve_alert(starve_alert)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int port, input logic [3:0] tgt, input logic [7:0] d, input bit expect_out);
        logic [15:0] p;
        p = {4'(port), tgt, d};
        fifo[port].push_back(p);
        if (expect_out) exp_q.push_back({2'(port), p});
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            if (fifo[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_source[4*i +: 4] = fifo[i][0][15:12];
                req_target[4*i +: 4] = fifo[i][0][11:8];
                req_data[DW*i +: DW] = fifo[i][0][7:0];
            end else begin
                req_valid[i]         = 1'b0;
                req_source[4*i +: 4] = '0;
                req_target[4*i +: 4] = '0;
                req_data[DW*i +: DW] = '0;
            end
        end
    endtask

    // One clock: sample served/starve mid-cycle, then pop the served heads.
    task automatic step(output logic [3:0] s, output logic st);
        logic [3:0] rq;
        @(negedge clk);
        s  = served;
        st = starve_alert;
        for (int i = 0; i < NP; i++)
            rq[i] = (fifo[i].size() > 0) && fifo[i][0][8+PID];
        check("served_legal", 32'(((s & ~rq) == 4'b0) && $onehot0(s)), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++)
            if (s[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        drive();
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: got %h expected none",
                         {grant_idx, out_source, out_target, out_data});
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({grant_idx, out_source, out_target, out_data} !== e) begin
                    miscompares++;
                    $display("FAIL out_packet: got %h expected %h",
                             {grant_idx, out_source, out_target, out_data}, e);
                end
            end
        end
    end

    initial begin
        logic [3:0] s;
        logic       st;
        rst = 1'b1; out_ready = 1'b1;
        req_valid = '0; req_source = '0; req_target = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_served", 32'(served), 32'd0);
        check("rst_starve", 32'(starve_alert), 32'd0);
        check("rst_grant", 32'(grant_idx), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        rst = 1'b0;

        // single request from port 0
        push(0, 4'b0010, 8'hA5, 1'b1);
        drive();
        step(s, st);
        check("single_served", 32'(s), 32'h1);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_grant", 32'(grant_idx), 32'd0);
        check("single_data", 32'(out_data), 32'hA5);
        step(s, st);
        check("single_idle", 32'(out_valid), 32'd0);

        // fairness from a fresh pointer: 0,1,2,3 repeating, one per cycle
        rst = 1'b1; #2; rst = 1'b0;
        for (int n = 0; n < 3; n++)
            for (int i = 0; i < NP; i++)
                push(i, 4'b0010, 8'(8'h10 * i + n), 1'b1);
        drive();
        for (int k = 0; k < 12; k++) begin
            step(s, st);
            check("fair_served", 32'(s), 32'(1 << (k % 4)));
        end
        step(s, st);
        check("fair_idle_served", 32'(s), 32'd0);

        // backpressure: port 0 held for 5 cycles, port 2 loads on release
        push(0, 4'b0010, 8'hC0, 1'b1);
        push(2, 4'b0010, 8'hC2, 1'b1);
        drive();
        step(s, st);
        check("bp_first", 32'(s), 32'h1);
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step(s, st);
            check("bp_served", 32'(s), 32'd0);
            check("bp_data", 32'(out_data), 32'hC0);
            check("bp_grant", 32'(grant_idx), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step(s, st);
        check("bp_release", 32'(s), 32'h4);
        check("bp_next_data", 32'(out_data), 32'hC2);
        step(s, st);
        check("bp_drain", 32'(s), 32'd0);

        // starvation: port 2 waits behind a stalled port-0 packet
        push(0, 4'b0010, 8'hD0, 1'b1);
        push(2, 4'b0010, 8'hD2, 1'b1);
        drive();
        step(s, st);
        check("starve_load", 32'(s), 32'h1);
        check("starve_init", 32'(st), 32'd0);
        out_ready = 1'b0;
        for (int j = 2; j <= 20; j++) begin
            step(s, st);
            check("starve_level", 32'(st), 32'(j >= 16));
        end
        out_ready = 1'b1;
        step(s, st);
        check("starve_serve", 32'(s), 32'h4);
        check("starve_held", 32'(st), 32'd1);
        step(s, st);
        check("starve_clear", 32'(st), 32'd0);

        // target filter: port 3 head addressed to output 2 only
        push(3, 4'b0100, 8'hE3, 1'b0);
        drive();
        for (int j = 0; j < 5; j++) begin
            step(s, st);
            check("filter_served", 32'(s), 32'd0);
            check("filter_valid", 32'(out_valid), 32'd0);
        end
        fifo[3].delete();
        drive();

        // async reset while holding port 1: packet dropped, pointer restarts at 0
        push(1, 4'b0010, 8'hF1, 1'b0);
        drive();
        step(s, st);
        check("ar_load", 32'(s), 32'h2);
        out_ready = 1'b0;
        step(s, st);
        check("ar_hold", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_grant", 32'(grant_idx), 32'd0);
        check("ar_data", 32'(out_data), 32'd0);
        check("ar_served", 32'(served), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        push(0, 4'b0010, 8'h0F, 1'b1);
        push(3, 4'b0010, 8'h3F, 1'b1);
        out_ready = 1'b1;
        drive();
        step(s, st);
        check("ar_first", 32'(s), 32'h1);
        step(s, st);
        check("ar_second", 32'(s), 32'h8);

        for (int j = 0; j < 20 && exp_q.size() > 0; j++) step(s, st);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
